// File: rtl/tlp_tx_arbiter.sv
// Two-requester arbiter for the 16-bit PCIe TLP transmit port: grants one source,
// runs the tx_req/tx_rdy handshake, then passes that source's beats straight through.
module tlp_tx_arbiter #(
    parameter int MAX_BEATS  = 512,
    parameter int CNT_W      = 10,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk_125,
    input  logic        sys_rst,
    input  logic        a_req,
    output logic        a_gnt,
    output logic        a_rdy,
    input  logic        a_st,
    input  logic        a_end,
    input  logic [15:0] a_data,
    input  logic        b_req,
    output logic        b_gnt,
    output logic        b_rdy,
    input  logic        b_st,
    input  logic        b_end,
    input  logic [15:0] b_data,
    output logic        tx_req,
    input  logic        tx_rdy,
    output logic        tx_st,
    output logic        tx_end,
    output logic [15:0] tx_data,
    output logic        busy,
    output logic        err_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(MAX_BEATS - 1);

    state_t           r_state, w_state_nx;
    logic             r_sel, w_sel_nx;     // 0 = A, 1 = B
    logic             r_last, w_last_nx;   // last requester that completed a TLP
    logic             r_a_gnt, w_a_gnt_nx;
    logic             r_b_gnt, w_b_gnt_nx;
    logic             r_tx_req, w_tx_req_nx;
    logic             r_err, w_err_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;

    logic        w_xfer;
    logic        w_sel_req;
    logic        w_sel_st;
    logic        w_sel_end;
    logic [15:0] w_sel_data;
    logic        w_force_end;
    logic        w_beat;
    logic        w_last_beat;
    logic        w_winner;

    assign w_xfer      = (r_state == ST_XFER);
    assign w_sel_req   = r_sel ? b_req  : a_req;
    assign w_sel_st    = r_sel ? b_st   : a_st;
    assign w_sel_end   = r_sel ? b_end  : a_end;
    assign w_sel_data  = r_sel ? b_data : a_data;
    assign w_force_end = (r_cnt == LP_CNT_LAST);
    assign w_beat      = w_xfer & tx_rdy;
    assign w_last_beat = w_beat & (w_sel_end | w_force_end);

    // B wins when alone, or on a tie in round-robin mode when A was served last.
    assign w_winner = b_req & (~a_req | ((FIXED_PRIO == 1'b0) & ~r_last));

    always_ff @(posedge clk_125) begin
        if (sys_rst) begin
            r_state  <= ST_IDLE;
            r_sel    <= 1'b0;
            r_last   <= 1'b1;
            r_a_gnt  <= 1'b0;
            r_b_gnt  <= 1'b0;
            r_tx_req <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_sel    <= w_sel_nx;
            r_last   <= w_last_nx;
            r_a_gnt  <= w_a_gnt_nx;
            r_b_gnt  <= w_b_gnt_nx;
            r_tx_req <= w_tx_req_nx;
            r_err    <= w_err_nx;
            r_cnt    <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_sel_nx    = r_sel;
        w_last_nx   = r_last;
        w_a_gnt_nx  = r_a_gnt;
        w_b_gnt_nx  = r_b_gnt;
        w_tx_req_nx = r_tx_req;
        w_err_nx    = r_err;
        w_cnt_nx    = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (a_req | b_req) begin
                    w_state_nx  = ST_REQ;
                    w_sel_nx    = w_winner;
                    w_a_gnt_nx  = ~w_winner;
                    w_b_gnt_nx  = w_winner;
                    w_tx_req_nx = 1'b1;
                end
            end
            ST_REQ: begin
                // Withdrawal beats a simultaneous tx_rdy.
                if (!w_sel_req) begin
                    w_state_nx  = ST_IDLE;
                    w_a_gnt_nx  = 1'b0;
                    w_b_gnt_nx  = 1'b0;
                    w_tx_req_nx = 1'b0;
                end else if (tx_rdy) begin
                    w_state_nx  = ST_XFER;
                    w_tx_req_nx = 1'b0;
                    w_cnt_nx    = '0;
                end
            end
            ST_XFER: begin
                if (w_last_beat) begin
                    w_state_nx = ST_IDLE;
                    w_a_gnt_nx = 1'b0;
                    w_b_gnt_nx = 1'b0;
                    w_last_nx  = r_sel;
                    if (!w_sel_end) begin
                        w_err_nx = 1'b1;
                    end
                end else if (w_beat) begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign a_gnt       = r_a_gnt;
    assign b_gnt       = r_b_gnt;
    assign a_rdy       = w_beat & ~r_sel;
    assign b_rdy       = w_beat & r_sel;
    assign tx_req      = r_tx_req;
    assign tx_st       = w_beat & w_sel_st;
    assign tx_end      = w_last_beat;
    assign tx_data     = w_xfer ? w_sel_data : 16'h0000;
    assign busy        = (r_state != ST_IDLE);
    assign err_overrun = r_err;

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Bench for tlp_tx_arbiter: directed vector table, scripted corner sequences,
// and random stimulus against a transaction-level reference model.
module tb_tlp_tx_arbiter;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    // Instance 0: round-robin, instance 1: fixed priority; both MAX_BEATS = 8.
    logic [1:0]  rst, a_req, a_st, a_end, b_req, b_st, b_end, tx_rdy;
    logic [15:0] a_data [2];
    logic [15:0] b_data [2];
    logic [1:0]  a_gnt, a_rdy, b_gnt, b_rdy, tx_req, tx_st, tx_end, busy, err;
    logic [15:0] txd0, txd1;

    tlp_tx_arbiter #(.MAX_BEATS(8), .CNT_W(4), .FIXED_PRIO(1'b0)) dut0 (
        .clk_125(clk), .sys_rst(rst[0]),
        .a_req(a_req[0]), .a_gnt(a_gnt[0]), .a_rdy(a_rdy[0]), .a_st(a_st[0]), .a_end(a_end[0]), .a_data(a_data[0]),
        .b_req(b_req[0]), .b_gnt(b_gnt[0]), .b_rdy(b_rdy[0]), .b_st(b_st[0]), .b_end(b_end[0]), .b_data(b_data[0]),
        .tx_req(tx_req[0]), .tx_rdy(tx_rdy[0]), .tx_st(tx_st[0]), .tx_end(tx_end[0]), .tx_data(txd0),
        .busy(busy[0]), .err_overrun(err[0])
    );

    tlp_tx_arbiter #(.MAX_BEATS(8), .CNT_W(4), .FIXED_PRIO(1'b1)) dut1 (
        .clk_125(clk), .sys_rst(rst[1]),
        .a_req(a_req[1]), .a_gnt(a_gnt[1]), .a_rdy(a_rdy[1]), .a_st(a_st[1]), .a_end(a_end[1]), .a_data(a_data[1]),
        .b_req(b_req[1]), .b_gnt(b_gnt[1]), .b_rdy(b_rdy[1]), .b_st(b_st[1]), .b_end(b_end[1]), .b_data(b_data[1]),
        .tx_req(tx_req[1]), .tx_rdy(tx_rdy[1]), .tx_st(tx_st[1]), .tx_end(tx_end[1]), .tx_data(txd1),
        .busy(busy[1]), .err_overrun(err[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\", want \"%s\"", name, act, exp);
        end
    endtask

    // {a_gnt,a_rdy,b_gnt,b_rdy,tx_req,tx_st,tx_end,busy,err,tx_data}
    function automatic logic [24:0] outs(input int k);
        return {a_gnt[k], a_rdy[k], b_gnt[k], b_rdy[k], tx_req[k], tx_st[k], tx_end[k],
                busy[k], err[k], (k == 1) ? txd1 : txd0};
    endfunction

    task automatic idle_in(input int k);
        rst[k] = 1'b0; a_req[k] = 1'b0; a_st[k] = 1'b0; a_end[k] = 1'b0; a_data[k] = 16'h0;
        b_req[k] = 1'b0; b_st[k] = 1'b0; b_end[k] = 1'b0; b_data[k] = 16'h0; tx_rdy[k] = 1'b0;
    endtask

    typedef struct {
        logic        a_req, a_st, a_end;
        logic [15:0] a_data;
        logic        b_req, b_st, b_end;
        logic [15:0] b_data;
        logic        tx_rdy;
        logic [24:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic ar, input logic as_, input logic ae, input logic [15:0] ad,
                                input logic br, input logic bs, input logic be, input logic [15:0] bd,
                                input logic rdy, input logic [8:0] ef, input logic [15:0] ed);
        vec_t v;
        v.a_req = ar; v.a_st = as_; v.a_end = ae; v.a_data = ad;
        v.b_req = br; v.b_st = bs; v.b_end = be; v.b_data = bd;
        v.tx_rdy = rdy; v.exp = {ef, ed};
        return v;
    endfunction

    // Well-behaved requesters on instance k: each holds req while it has TLPs left,
    // presents beat idx, advances on its rdy. Optional one-off stall at beat stall_at.
    task automatic run_emu(input int k, input int a_tlps, input int a_len, input int b_tlps, input int b_len,
                           input int stall_at, input int stall_len, input int ncyc, output string order);
        int ai = 0, bi = 0, al = a_tlps, bl = b_tlps, stalls = 0, cur;
        bit pa = 0, pb = 0, stall, inx;
        order = "";
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            a_req[k]  = (al > 0);
            a_st[k]   = (ai == 0);
            a_end[k]  = (ai == a_len - 1);
            a_data[k] = 16'hA000 | 16'(((a_tlps - al) << 4) | ai);
            b_req[k]  = (bl > 0);
            b_st[k]   = (bi == 0);
            b_end[k]  = (bi == b_len - 1);
            b_data[k] = 16'hB000 | 16'(((b_tlps - bl) << 4) | bi);
            inx   = (a_gnt[k] | b_gnt[k]) & ~tx_req[k];
            cur   = a_gnt[k] ? ai : bi;
            stall = (stall_at >= 0) && inx && (cur == stall_at) && (stalls < stall_len);
            tx_rdy[k] = ~stall;
            #1;
            if (a_gnt[k] && !pa) order = {order, "A"};
            if (b_gnt[k] && !pb) order = {order, "B"};
            pa = a_gnt[k];
            pb = b_gnt[k];
            if (stall) begin
                stalls++;
                chk("stall_quiet", 64'({a_rdy[k], b_rdy[k], tx_st[k], tx_end[k]}), 64'h0);
            end
            if (a_rdy[k]) begin
                chk("beat_a", 64'({tx_st[k], tx_end[k], (k == 1) ? txd1 : txd0}),
                    64'({a_st[k], a_end[k], a_data[k]}));
                ai++;
                if (ai == a_len) begin ai = 0; al--; end
            end
            if (b_rdy[k]) begin
                chk("beat_b", 64'({tx_st[k], tx_end[k], (k == 1) ? txd1 : txd0}),
                    64'({b_st[k], b_end[k], b_data[k]}));
                bi++;
                if (bi == b_len) begin bi = 0; bl--; end
            end
        end
        if (stall_at >= 0) chk("stall_cycles", 64'(stalls), 64'(stall_len));
        chk("all_delivered", 64'({al[15:0], bl[15:0]}), 64'h0);
        idle_in(k);
    endtask

    // Reference model: who owns the port, whether the core handshake is pending,
    // beats sent so far in the current TLP, who finished last, sticky overrun.
    localparam int MAXB = 8;
    int m_own   [2];
    bit m_hs    [2];
    int m_beats [2];
    int m_last  [2];
    bit m_err   [2];
    bit m_fixed [2] = '{1'b0, 1'b1};

    task automatic model_reset(input int k);
        m_own[k] = -1; m_hs[k] = 0; m_beats[k] = 0; m_last[k] = 1; m_err[k] = 0;
    endtask

    function automatic logic [24:0] model_out(input int k);
        bit          xfer = (m_own[k] >= 0) && !m_hs[k];
        bit          go   = xfer && tx_rdy[k];
        bit          fe   = (m_beats[k] == MAXB - 1);
        logic        st   = (m_own[k] == 1) ? b_st[k]   : a_st[k];
        logic        en   = (m_own[k] == 1) ? b_end[k]  : a_end[k];
        logic [15:0] d    = (m_own[k] == 1) ? b_data[k] : a_data[k];
        return {m_own[k] == 0, go && m_own[k] == 0, m_own[k] == 1, go && m_own[k] == 1,
                (m_own[k] >= 0) && m_hs[k], go && st, go && (en || fe), m_own[k] >= 0,
                m_err[k], xfer ? d : 16'h0};
    endfunction

    task automatic model_step(input int k);
        bit en, rq;
        if (rst[k]) begin
            model_reset(k);
        end else if (m_own[k] < 0) begin
            if (a_req[k] || b_req[k]) begin
                if (a_req[k] && !b_req[k])      m_own[k] = 0;
                else if (!a_req[k] && b_req[k]) m_own[k] = 1;
                else                            m_own[k] = m_fixed[k] ? 0 : 1 - m_last[k];
                m_hs[k] = 1;
            end
        end else if (m_hs[k]) begin
            rq = (m_own[k] == 0) ? a_req[k] : b_req[k];
            if (!rq) m_own[k] = -1;
            else if (tx_rdy[k]) begin m_hs[k] = 0; m_beats[k] = 0; end
        end else if (tx_rdy[k]) begin
            en = (m_own[k] == 0) ? a_end[k] : b_end[k];
            if (en || m_beats[k] == MAXB - 1) begin
                if (!en) m_err[k] = 1;
                m_last[k] = m_own[k];
                m_own[k]  = -1;
            end else begin
                m_beats[k]++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t  tbl [16];
        string ord;
        int    n, endat;
        bit    seen, hit;

        idle_in(0); idle_in(1);
        rst = 2'b11;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_state0", 64'(outs(0)), 64'h0);
        chk("reset_state1", 64'(outs(1)), 64'h0);
        rst = 2'b00;

        // Packet from A with one stall, then single-beat B, then an A withdrawal
        // that coincides with tx_rdy.
        tbl[0]  = mk(1,0,0,16'h0000, 0,0,0,16'h0000, 0, 9'b000000000, 16'h0000);
        tbl[1]  = mk(1,0,0,16'h0000, 0,0,0,16'h0000, 1, 9'b100010010, 16'h0000);
        tbl[2]  = mk(1,1,0,16'h1111, 0,0,0,16'h0000, 1, 9'b110001010, 16'h1111);
        tbl[3]  = mk(1,0,0,16'h2222, 0,1,0,16'hBEEF, 1, 9'b110000010, 16'h2222);
        tbl[4]  = mk(1,0,0,16'h3333, 0,0,0,16'h0000, 0, 9'b100000010, 16'h3333);
        tbl[5]  = mk(1,0,0,16'h3333, 0,0,0,16'h0000, 1, 9'b110000010, 16'h3333);
        tbl[6]  = mk(0,0,1,16'h4444, 0,0,0,16'h0000, 1, 9'b110000110, 16'h4444);
        tbl[7]  = mk(0,0,0,16'h0000, 0,0,0,16'h0000, 1, 9'b000000000, 16'h0000);
        tbl[8]  = mk(0,0,0,16'h0000, 1,0,0,16'h0000, 1, 9'b000000000, 16'h0000);
        tbl[9]  = mk(0,0,0,16'h0000, 1,0,0,16'h0000, 0, 9'b001010010, 16'h0000);
        tbl[10] = mk(0,0,0,16'h0000, 1,1,1,16'h5555, 1, 9'b001010010, 16'h0000);
        tbl[11] = mk(0,0,0,16'h0000, 0,1,1,16'h5555, 1, 9'b001101110, 16'h5555);
        tbl[12] = mk(0,0,0,16'h0000, 0,0,0,16'h0000, 0, 9'b000000000, 16'h0000);
        tbl[13] = mk(1,0,0,16'h0000, 0,0,0,16'h0000, 0, 9'b000000000, 16'h0000);
        tbl[14] = mk(0,0,0,16'h0000, 0,0,0,16'h0000, 1, 9'b100010010, 16'h0000);
        tbl[15] = mk(0,0,0,16'h0000, 0,0,0,16'h0000, 0, 9'b000000000, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            a_req[0] = tbl[i].a_req; a_st[0] = tbl[i].a_st; a_end[0] = tbl[i].a_end; a_data[0] = tbl[i].a_data;
            b_req[0] = tbl[i].b_req; b_st[0] = tbl[i].b_st; b_end[0] = tbl[i].b_end; b_data[0] = tbl[i].b_data;
            tx_rdy[0] = tbl[i].tx_rdy;
            #1;
            chk($sformatf("vec%0d", i), 64'(outs(0)), 64'(tbl[i].exp));
        end
        idle_in(0);

        // Withdrawal in REQ while the core is not ready; B then granted.
        @(posedge clk); #1; a_req[0] = 1'b1; #1;
        @(posedge clk); #1; a_req[0] = 1'b0; b_req[0] = 1'b1; #1;
        chk("wd_req", 64'({a_gnt[0], tx_req[0]}), 64'b11);
        @(posedge clk); #2;
        chk("wd_drop", 64'({a_gnt[0], tx_req[0], busy[0]}), 64'b000);
        @(posedge clk); #1; b_req[0] = 1'b0; #1;
        chk("wd_b_gnt", 64'({b_gnt[0], a_gnt[0], tx_req[0]}), 64'b101);
        @(posedge clk); #2;
        chk("wd_idle", 64'(busy[0]), 64'h0);

        run_emu(0, 2, 2, 2, 2, -1, 0, 40, ord);
        chk_str("rr_order", ord, "ABAB");
        run_emu(0, 0, 2, 1, 6, 2, 3, 30, ord);
        chk_str("stall_order", ord, "B");
        run_emu(1, 3, 2, 1, 2, -1, 0, 40, ord);
        chk_str("fixed_order", ord, "AAAB");

        // Overrun: B never raises end; truncated at beat 8, then drops req.
        chk("ovr_err_pre", 64'(err[0]), 64'h0);
        n = 0; endat = 0; seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            b_req[0] = ~seen; b_data[0] = 16'hC000 + 16'(n); b_st[0] = (n == 0); b_end[0] = 1'b0;
            tx_rdy[0] = 1'b1;
            #1;
            if (b_rdy[0]) begin
                n++;
                if (tx_end[0]) begin endat = n; seen = 1; end
            end
        end
        chk("ovr_end_beat", 64'(endat), 64'd8);
        chk("ovr_beats", 64'(n), 64'd8);
        chk("ovr_state", 64'({err[0], busy[0], b_gnt[0]}), 64'b100);
        idle_in(0);
        run_emu(0, 1, 2, 0, 0, -1, 0, 12, ord);
        chk("ovr_sticky", 64'(err[0]), 64'h1);

        // Reset at beat 3 of a B packet while A was last served.
        n = 0; hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(posedge clk); #1;
            b_req[0] = 1'b1; b_data[0] = 16'hD000 + 16'(n); b_st[0] = (n == 0); b_end[0] = 1'b0;
            tx_rdy[0] = 1'b1;
            rst[0] = (n == 2) && b_gnt[0] && !tx_req[0];
            #1;
            if (b_rdy[0]) n++;
            if (rst[0]) hit = 1;
        end
        @(posedge clk); #1;
        rst[0] = 1'b0; a_req[0] = 1'b1; b_req[0] = 1'b1; b_data[0] = 16'h0; tx_rdy[0] = 1'b0;
        #1;
        chk("rst_hit", 64'(hit), 64'h1);
        chk("rst_clear", 64'(outs(0)), 64'h0);
        @(posedge clk); #2;
        chk("rst_first_gnt", 64'({a_gnt[0], b_gnt[0], tx_req[0]}), 64'b101);
        idle_in(0);
        @(posedge clk); @(posedge clk);

        // Random stimulus, both instances, against the model.
        rst = 2'b11;
        @(posedge clk); @(posedge clk);
        model_reset(0); model_reset(1);
        for (int c = 0; c < 3000; c++) begin
            logic        r, ar, as_, ae, br, bs, be, rdy;
            logic [15:0] ad, bd;
            @(posedge clk); #1;
            r   = ($urandom_range(0, 199) == 0);
            ar  = ($urandom_range(0, 3) != 0);
            as_ = ($urandom_range(0, 3) == 0);
            ae  = ($urandom_range(0, 4) == 0);
            ad  = 16'($urandom);
            br  = ($urandom_range(0, 3) != 0);
            bs  = ($urandom_range(0, 3) == 0);
            be  = ($urandom_range(0, 4) == 0);
            bd  = 16'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 2; k++) begin
                rst[k] = r; a_req[k] = ar; a_st[k] = as_; a_end[k] = ae; a_data[k] = ad;
                b_req[k] = br; b_st[k] = bs; b_end[k] = be; b_data[k] = bd; tx_rdy[k] = rdy;
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                chk((k == 0) ? "rand_rr" : "rand_fixed", 64'(outs(k)), 64'(model_out(k)));
                model_step(k);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
